req_pulse_arbiter: RTL and testbench
====================================

REQ_PULSE_ARBITER -- requirements
Module: req_pulse_arbiter

Interface
REQ-001 Parameter CNT_W, default 3, width of each per-master pending-event counter.
REQ-002 ACLK  input  1  sole clock; all state updates on rising edge.
REQ-003 ARESETN  input  1  asynchronous, active-low reset.
REQ-004 req_pulse  input  2  per-master new-request event, one bit per master; each cycle high = one event.
REQ-005 txn_done  input  1  single-cycle pulse; current granted transaction finished.
REQ-006 grant  output  2  one-hot grant, registered; all-zero when no grant.
REQ-007 grant_id  output  1  index of granted master; valid only while busy=1.
REQ-008 busy  output  1  high while a grant is held.
REQ-009 overflow  output  2  per-master sticky flag, set when an event is lost.
REQ-010 pend_cnt0, pend_cnt1  output  CNT_W  current pending-event counts, for status/debug.

Function
REQ-011 FSM SHALL have two states: IDLE and BUSY; grant/busy/grant_id are registered outputs of the FSM.
REQ-012 IDLE: if any pend_cnt > 0, SHALL move to BUSY next edge, asserting grant for the selected master and decrementing that master's counter on that edge.
REQ-013 Selection: only one master pending -> that master; both pending -> master != last_grant (round-robin).
REQ-014 last_grant SHALL update to grant_id on each IDLE->BUSY transition.
REQ-015 BUSY: grant, grant_id, busy SHALL hold constant until txn_done=1; on that edge SHALL return to IDLE with grant=0, busy=0.
REQ-016 BUSY->IDLE SHALL always insert at least one IDLE cycle; no back-to-back grant on the same edge as txn_done.
REQ-017 txn_done in IDLE SHALL be ignored with no state change.
REQ-018 Latency: req_pulse high at edge t with counter 0 and FSM IDLE -> counter 1 after t, grant high after edge t+1.
REQ-019 Counter: req_pulse alone -> +1; decrement alone -> -1; both in same cycle -> unchanged.
REQ-020 Counter at max (2^CNT_W-1) with req_pulse and no decrement SHALL stay at max and set overflow for that master.
REQ-021 overflow SHALL stay set until reset; it SHALL NOT be cleared by traffic.
REQ-022 Counter SHALL never decrement below zero; decrement occurs only on grant issue.
REQ-023 Simultaneous req_pulse on both masters SHALL increment both counters independently.

Reset
REQ-024 ARESETN low SHALL immediately force: state IDLE, grant=0, grant_id=0, busy=0, overflow=0, both counters 0, last_grant=1 (master 0 wins first tie).
REQ-025 Reset asserted mid-BUSY SHALL drop grant asynchronously; all pending events are discarded.
REQ-026 First grant after deassertion SHALL be no earlier than the second rising ACLK edge after ARESETN rises.

Structure
REQ-027 Shared package SHALL hold the state encoding (IDLE, BUSY) and the CNT_W default constant.
REQ-028 One sub-module, pend_counter, SHALL implement a single saturating up/down counter with sticky overflow; instantiated twice.
REQ-029 Arbitration and FSM SHALL live in req_pulse_arbiter; no combinational path from any input to any output.

Verification
REQ-030 Single pulse: req_pulse=01 at edge 5 -> pend_cnt0=1 after edge 5; grant=01, grant_id=0, busy=1 after edge 6; pend_cnt0=0; txn_done at edge 10 -> grant=00 after edge 10.
REQ-031 Tie after reset: req_pulse=11 one cycle -> first grant=01; txn_done; one IDLE cycle; then grant=10.
REQ-032 Round-robin fairness: master 0 pulses 4 times, master 1 pulses 4 times, done 2 cycles after each grant -> grants alternate 0,1,0,1,... for 8 grants; no overflow.
REQ-033 Overflow: CNT_W=3, busy held, master 1 pulses 8 cycles -> pend_cnt1=7, overflow=10; after draining all 7 grants overflow remains 10.
REQ-034 Simultaneous increment/decrement: pend_cnt0=2, FSM IDLE, req_pulse=01 on the grant-issue edge -> pend_cnt0 stays 2, grant=01.
REQ-035 Reset mid-BUSY: ARESETN low while grant=10, pend_cnt0=3 -> grant=00, busy=0, counters 0 immediately; after release, no grant without new pulses.

Source files
------------

// File: rtl/req_pulse_arbiter_pkg.sv
// Shared types and constants for the two-master pulse arbiter.
package req_pulse_arbiter_pkg;

  localparam int unsigned CNT_W_DEFAULT = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One-hot grant vector for a master index.
  function automatic logic [1:0] onehot(input logic idx);
    onehot = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/req_pulse_arbiter_if.sv
// Request/grant bundle between the masters' side and the arbiter.
interface req_pulse_arbiter_if
  import req_pulse_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
);
  logic [1:0]       req_pulse;
  logic             txn_done;
  logic [1:0]       grant;
  logic             grant_id;
  logic             busy;
  logic [1:0]       overflow;
  logic [CNT_W-1:0] pend_cnt0;
  logic [CNT_W-1:0] pend_cnt1;

  modport master (
    output req_pulse, txn_done,
    input  grant, grant_id, busy, overflow, pend_cnt0, pend_cnt1
  );

  modport slave (
    input  req_pulse, txn_done,
    output grant, grant_id, busy, overflow, pend_cnt0, pend_cnt1
  );
endinterface

// File: rtl/req_pulse_arbiter_pend_counter.sv
// Saturating pending-event counter with a sticky overflow flag.
module pend_counter
  import req_pulse_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count events up, grants down; a simultaneous inc/dec cancels out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (cnt == CNT_MAX) overflow <= 1'b1;
          else                cnt      <= cnt + 1'b1;
        end
        2'b01: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/req_pulse_arbiter.sv
// Two-master round-robin arbiter fed by per-master request pulse counters.
module req_pulse_arbiter
  import req_pulse_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  req_pulse_arbiter_if.slave    bus
);

  state_t           state;
  logic [1:0]       grant;
  logic             grant_id;
  logic             busy;
  logic             last_grant;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             ovf0;
  logic             ovf1;
  logic             sel;
  logic             issue;

  // Pick the next master from registered counts only, so no input reaches an output combinationally.
  always_comb begin
    sel = 1'b0;
    if ((cnt0 != '0) && (cnt1 != '0)) sel = ~last_grant;
    else if (cnt1 != '0)              sel = 1'b1;
  end

  assign issue = (state == IDLE) && ((cnt0 != '0) || (cnt1 != '0));

  pend_counter #(.CNT_W(CNT_W)) u_cnt0 (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .inc      (bus.req_pulse[0]),
    .dec      (issue && !sel),
    .cnt      (cnt0),
    .overflow (ovf0)
  );

  pend_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .inc      (bus.req_pulse[1]),
    .dec      (issue && sel),
    .cnt      (cnt1),
    .overflow (ovf1)
  );

  // Grant FSM: issue from IDLE, hold until txn_done, then always rest one cycle in IDLE.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      grant      <= '0;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state      <= BUSY;
            grant      <= onehot(sel);
            grant_id   <= sel;
            busy       <= 1'b1;
            last_grant <= sel;
          end
        end
        BUSY: begin
          if (bus.txn_done) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant;
  assign bus.grant_id  = grant_id;
  assign bus.busy      = busy;
  assign bus.overflow  = {ovf1, ovf0};
  assign bus.pend_cnt0 = cnt0;
  assign bus.pend_cnt1 = cnt1;

endmodule

// File: tb/tb_req_pulse_arbiter.sv
// Directed, table-driven check of req_pulse_arbiter with CNT_W=3.
module tb_req_pulse_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  req_pulse_arbiter_if #(.CNT_W(3)) bus ();

  req_pulse_arbiter #(.CNT_W(3)) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0] rp;
    logic       td;
    logic [1:0] g;
    logic       id;
    logic       b;
    logic [2:0] c0;
    logic [2:0] c1;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] rp, input logic td, input logic [1:0] g,
                              input logic id, input logic b, input logic [2:0] c0,
                              input logic [2:0] c1);
    vec_t v;
    v.rp = rp; v.td = td; v.g = g; v.id = id; v.b = b; v.c0 = c0; v.c1 = c1;
    vecs.push_back(v);
  endfunction

  // Grant issued, held one cycle, then txn_done (done two cycles after the grant).
  function automatic void grant3(input logic [1:0] g, input logic id,
                                 input logic [2:0] c0, input logic [2:0] c1);
    add(2'b00, 1'b0, g, id, 1'b1, c0, c1);
    add(2'b00, 1'b0, g, id, 1'b1, c0, c1);
    add(2'b00, 1'b1, 2'b00, id, 1'b0, c0, c1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle and sample just after the rising edge.
  task automatic step(input logic [1:0] rp, input logic td);
    @(negedge clk);
    bus.req_pulse = rp;
    bus.txn_done  = td;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;

    // Tie after reset: master 0 first, one idle cycle, then master 1.
    add(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0);
    add(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1, 3'd1);
    add(2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 3'd0, 3'd1);
    add(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 3'd1);
    add(2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 3'd0, 3'd0);
    add(2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 3'd0, 3'd0);
    add(2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 3'd0, 3'd0);
    // Round-robin: four pulses per master, grants alternate 0,1,0,1,...
    add(2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 3'd1, 3'd1);
    add(2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 3'd1, 3'd2);
    add(2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 3'd2, 3'd3);
    add(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 3'd3, 3'd4);
    grant3(2'b10, 1'b1, 3'd3, 3'd3);
    grant3(2'b01, 1'b0, 3'd2, 3'd3);
    grant3(2'b10, 1'b1, 3'd2, 3'd2);
    grant3(2'b01, 1'b0, 3'd1, 3'd2);
    grant3(2'b10, 1'b1, 3'd1, 3'd1);
    grant3(2'b01, 1'b0, 3'd0, 3'd1);
    grant3(2'b10, 1'b1, 3'd0, 3'd0);
    add(2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 3'd0, 3'd0);
    // Single pulse: count after one edge, grant after the next.
    add(2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 3'd1, 3'd0);
    add(2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 3'd0, 3'd0);
    add(2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 3'd0, 3'd0);
    add(2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 3'd0, 3'd0);
    add(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0);
    // Simultaneous increment and decrement on grant-issue edges.
    add(2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1, 3'd0);
    add(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 3'd1, 3'd0);
    add(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 3'd2, 3'd0);
    add(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 3'd2, 3'd0);
    add(2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 3'd2, 3'd0);
    add(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 3'd2, 3'd0);
    add(2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 3'd1, 3'd0);
    add(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 3'd1, 3'd0);
    add(2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 3'd0, 3'd0);
    add(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0);
    add(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0);

    bus.req_pulse = 2'b00;
    bus.txn_done  = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("reset grant", int'(bus.grant), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset grant_id", int'(bus.grant_id), 0);
    chk("reset overflow", int'(bus.overflow), 0);
    chk("reset cnt0", int'(bus.pend_cnt0), 0);
    chk("reset cnt1", int'(bus.pend_cnt1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].rp, vecs[i].td);
      chk($sformatf("v%0d grant", i), int'(bus.grant), int'(vecs[i].g));
      chk($sformatf("v%0d busy", i), int'(bus.busy), int'(vecs[i].b));
      if (vecs[i].b) chk($sformatf("v%0d grant_id", i), int'(bus.grant_id), int'(vecs[i].id));
      chk($sformatf("v%0d cnt0", i), int'(bus.pend_cnt0), int'(vecs[i].c0));
      chk($sformatf("v%0d cnt1", i), int'(bus.pend_cnt1), int'(vecs[i].c1));
      chk($sformatf("v%0d overflow", i), int'(bus.overflow), 0);
    end

    // Overflow: hold a master-0 grant while master 1 pulses eight times.
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    chk("ovf setup grant", int'(bus.grant), 1);
    for (int k = 0; k < 8; k++) step(2'b10, 1'b0);
    chk("ovf cnt1 sat", int'(bus.pend_cnt1), 7);
    chk("ovf flag", int'(bus.overflow), 2);
    chk("ovf grant held", int'(bus.grant), 1);
    step(2'b00, 1'b1);
    for (int k = 0; k < 7; k++) begin
      got = 1'b0;
      for (int w = 0; w < 5 && !got; w++) begin
        step(2'b00, 1'b0);
        got = bus.busy;
      end
      chk($sformatf("drain%0d busy", k), int'(got), 1);
      chk($sformatf("drain%0d grant", k), int'(bus.grant), 2);
      chk($sformatf("drain%0d cnt1", k), int'(bus.pend_cnt1), 6 - k);
      step(2'b00, 1'b1);
    end
    step(2'b00, 1'b0);
    chk("drain idle", int'(bus.busy), 0);
    chk("ovf sticky", int'(bus.overflow), 2);

    // Reset mid-BUSY with master 1 granted and three master-0 events pending.
    step(2'b10, 1'b0);
    step(2'b00, 1'b0);
    chk("mid grant", int'(bus.grant), 2);
    for (int k = 0; k < 3; k++) step(2'b01, 1'b0);
    chk("mid cnt0", int'(bus.pend_cnt0), 3);
    @(negedge clk);
    bus.req_pulse = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async grant", int'(bus.grant), 0);
    chk("async busy", int'(bus.busy), 0);
    chk("async cnt0", int'(bus.pend_cnt0), 0);
    chk("async cnt1", int'(bus.pend_cnt1), 0);
    chk("async overflow", int'(bus.overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(2'b00, 1'b0);
      chk($sformatf("post rst%0d grant", k), int'(bus.grant), 0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
